// File: rtl/lsu_ctrl_if.sv
// Memory-side bus of the load/store unit: one read channel and one write channel,
// each using a valid/ready handshake.
interface lsu_ctrl_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Per-thread load/store unit: one read or write per instruction, result held until UPDATE.
// Optional WAITING watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 mem_read_enable,
    input  logic                 mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    lsu_ctrl_if.master           mem,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUESTING = 2'd1,
        WAITING    = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic                 is_read_reg, is_read_next;
    logic                 read_valid_reg, read_valid_next;
    logic                 write_valid_reg, write_valid_next;
    logic [ADDR_BITS-1:0] read_addr_reg, read_addr_next;
    logic [ADDR_BITS-1:0] write_addr_reg, write_addr_next;
    logic [DATA_BITS-1:0] write_data_reg, write_data_next;
    logic [DATA_BITS-1:0] lsu_out_reg, lsu_out_next;
    logic [ADDR_BITS-1:0] rs_addr;
    logic                 start;
    logic                 sel_ready;

    // rs is zero-extended or truncated to the address width
    generate
        if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
            assign rs_addr = rs[ADDR_BITS-1:0];
        end else begin : g_addr_ext
            assign rs_addr = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
        end
    endgenerate

    assign start = enable && (core_state == CORE_REQUEST) &&
                   (mem_read_enable || mem_write_enable);
    assign sel_ready = is_read_reg ? mem.mem_read_ready : mem.mem_write_ready;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_BITS = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
    logic [CNT_BITS-1:0] cnt_reg, cnt_next;
    logic                error_reg, error_next;
    assign lsu_error = error_reg;
`else
    assign lsu_error = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        is_read_next     = is_read_reg;
        read_valid_next  = read_valid_reg;
        write_valid_next = write_valid_reg;
        read_addr_next   = read_addr_reg;
        write_addr_next  = write_addr_reg;
        write_data_next  = write_data_reg;
        lsu_out_next     = lsu_out_reg;
`ifdef LSU_TIMEOUT_EN
        cnt_next         = cnt_reg;
        error_next       = error_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    // a load takes priority when both enables are set
                    is_read_next = mem_read_enable;
                    if (mem_read_enable) begin
                        read_addr_next = rs_addr;
                    end else begin
                        write_addr_next = rs_addr;
                        write_data_next = rt;
                    end
`ifdef LSU_TIMEOUT_EN
                    error_next = 1'b0;
`endif
                    state_next = REQUESTING;
                end
            end
            REQUESTING: begin
                if (is_read_reg) read_valid_next = 1'b1;
                else             write_valid_next = 1'b1;
`ifdef LSU_TIMEOUT_EN
                cnt_next = '0;
`endif
                state_next = WAITING;
            end
            WAITING: begin
                if (sel_ready) begin
                    read_valid_next  = 1'b0;
                    write_valid_next = 1'b0;
                    if (is_read_reg) lsu_out_next = mem.mem_read_data;
                    state_next = DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_reg == CNT_LAST) begin
                    read_valid_next  = 1'b0;
                    write_valid_next = 1'b0;
                    error_next       = 1'b1;
                    state_next       = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            DONE: begin
                if (core_state == CORE_UPDATE) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            is_read_reg     <= 1'b0;
            read_valid_reg  <= 1'b0;
            write_valid_reg <= 1'b0;
            read_addr_reg   <= '0;
            write_addr_reg  <= '0;
            write_data_reg  <= '0;
            lsu_out_reg     <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_reg         <= '0;
            error_reg       <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            is_read_reg     <= is_read_next;
            read_valid_reg  <= read_valid_next;
            write_valid_reg <= write_valid_next;
            read_addr_reg   <= read_addr_next;
            write_addr_reg  <= write_addr_next;
            write_data_reg  <= write_data_next;
            lsu_out_reg     <= lsu_out_next;
`ifdef LSU_TIMEOUT_EN
            cnt_reg         <= cnt_next;
            error_reg       <= error_next;
`endif
        end
    end

    assign mem.mem_read_valid    = read_valid_reg;
    assign mem.mem_read_address  = read_addr_reg;
    assign mem.mem_write_valid   = write_valid_reg;
    assign mem.mem_write_address = write_addr_reg;
    assign mem.mem_write_data    = write_data_reg;
    assign lsu_state             = state_reg;
    assign lsu_out               = lsu_out_reg;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: inputs driven and outputs sampled on the falling edge.
// With LSU_TIMEOUT_EN defined, also exercises the watchdog (TIMEOUT_CYCLES=4).
module tb_lsu_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       mem_read_enable;
    logic       mem_write_enable;
    logic [7:0] rs;
    logic [7:0] rt;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] REQ = 3'b011;
    localparam logic [2:0] UPD = 3'b110;
    localparam logic [2:0] OTH = 3'b000;

    lsu_ctrl_if #(.ADDR_BITS(8), .DATA_BITS(8)) mem ();

    lsu_ctrl #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .core_state       (core_state),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .rs               (rs),
        .rt               (rt),
        .mem              (mem.master),
        .lsu_state        (lsu_state),
        .lsu_out          (lsu_out),
        .lsu_error        (lsu_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        enable = 1'b0; core_state = OTH; mem_read_enable = 1'b0; mem_write_enable = 1'b0;
        mem.mem_read_ready = 1'b0; mem.mem_write_ready = 1'b0;
    endtask

    task automatic request(input logic en, input logic rd, input logic wr,
                           input logic [7:0] a, input logic [7:0] d);
        enable = en; core_state = REQ; mem_read_enable = rd; mem_write_enable = wr;
        rs = a; rt = d;
    endtask

    initial begin
        reset = 1'b1; rs = '0; rt = '0; mem.mem_read_data = '0;
        idle_inputs();
        step();

        // reset with random inputs for 2 cycles
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            enable = 1'($urandom); core_state = 3'($urandom);
            mem_read_enable = 1'($urandom); mem_write_enable = 1'($urandom);
            rs = 8'($urandom); rt = 8'($urandom);
            mem.mem_read_ready = 1'($urandom); mem.mem_write_ready = 1'($urandom);
            mem.mem_read_data = 8'($urandom);
            step();
        end
        check("rst_state", 32'(lsu_state), 0);
        check("rst_rvalid", 32'(mem.mem_read_valid), 0);
        check("rst_wvalid", 32'(mem.mem_write_valid), 0);
        check("rst_raddr", 32'(mem.mem_read_address), 0);
        check("rst_waddr", 32'(mem.mem_write_address), 0);
        check("rst_wdata", 32'(mem.mem_write_data), 0);
        check("rst_out", 32'(lsu_out), 0);
        check("rst_err", 32'(lsu_error), 0);
        $display("txn reset done");
        reset = 1'b1;
        idle_inputs();
        step();

        // load: rs=0x2A, ready in cycle 4 with data 0x5C; enable drops after acceptance
        request(1'b1, 1'b1, 1'b0, 8'h2A, 8'h00);
        step();                                          // cycle 1
        check("ld_c1_state", 32'(lsu_state), 1);
        check("ld_c1_rvalid", 32'(mem.mem_read_valid), 0);
        idle_inputs();
        step();                                          // cycle 2
        check("ld_c2_state", 32'(lsu_state), 2);
        check("ld_c2_rvalid", 32'(mem.mem_read_valid), 1);
        check("ld_raddr", 32'(mem.mem_read_address), 32'h2A);
        step();                                          // cycle 3
        check("ld_c3_rvalid", 32'(mem.mem_read_valid), 1);
        step();                                          // cycle 4
        check("ld_c4_rvalid", 32'(mem.mem_read_valid), 1);
        mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'h5C;
        step();                                          // cycle 5
        check("ld_c5_state", 32'(lsu_state), 3);
        check("ld_c5_rvalid", 32'(mem.mem_read_valid), 0);
        check("ld_out", 32'(lsu_out), 32'h5C);
        check("ld_raddr_hold", 32'(mem.mem_read_address), 32'h2A);
        mem.mem_read_ready = 1'b0; mem.mem_read_data = 8'h00;
        step();                                          // still DONE without UPDATE
        check("ld_done_hold", 32'(lsu_state), 3);
        core_state = UPD;
        step();
        check("ld_idle", 32'(lsu_state), 0);
        core_state = OTH;
        $display("txn load addr=0x2a data=0x5c");

        // store: rs=0x10, rt=0x77, ready on first valid cycle
        request(1'b1, 1'b0, 1'b1, 8'h10, 8'h77);
        step();
        idle_inputs();
        check("st_c1_state", 32'(lsu_state), 1);
        step();
        check("st_wvalid", 32'(mem.mem_write_valid), 1);
        check("st_rvalid", 32'(mem.mem_read_valid), 0);
        check("st_waddr", 32'(mem.mem_write_address), 32'h10);
        check("st_wdata", 32'(mem.mem_write_data), 32'h77);
        mem.mem_write_ready = 1'b1;
        step();
        check("st_wvalid_drop", 32'(mem.mem_write_valid), 0);
        check("st_state", 32'(lsu_state), 3);
        check("st_out_keep", 32'(lsu_out), 32'h5C);
        check("st_wdata_hold", 32'(mem.mem_write_data), 32'h77);
        mem.mem_write_ready = 1'b0; core_state = UPD;
        step();
        check("st_idle", 32'(lsu_state), 0);
        core_state = OTH;
        $display("txn store addr=0x10 data=0x77");

        // conflict: both enables -> read wins; write ready is ignored
        request(1'b1, 1'b1, 1'b1, 8'h33, 8'h99);
        step();
        idle_inputs();
        step();
        check("cf_rvalid", 32'(mem.mem_read_valid), 1);
        check("cf_wvalid", 32'(mem.mem_write_valid), 0);
        check("cf_raddr", 32'(mem.mem_read_address), 32'h33);
        check("cf_waddr_keep", 32'(mem.mem_write_address), 32'h10);
        mem.mem_write_ready = 1'b1;
        step();
        check("cf_wrdy_ignored", 32'(lsu_state), 2);
        mem.mem_write_ready = 1'b0; mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'hA5;
        step();
        check("cf_state", 32'(lsu_state), 3);
        check("cf_out", 32'(lsu_out), 32'hA5);
        mem.mem_read_ready = 1'b0; core_state = UPD;
        step();
        core_state = OTH;
        $display("txn conflict addr=0x33 data=0xa5");

        // gating: enable=0 at REQUEST, then enable=1 outside REQUEST
        request(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
        step();
        check("gate_en", 32'(lsu_state), 0);
        request(1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
        core_state = UPD;
        step();
        check("gate_phase", 32'(lsu_state), 0);
        check("gate_rvalid", 32'(mem.mem_read_valid), 0);
        idle_inputs();
        $display("txn gating");

        // reset mid-WAITING, later ready has no effect
        request(1'b1, 1'b1, 1'b0, 8'h44, 8'h00);
        step();
        idle_inputs();
        step();
        check("rw_rvalid", 32'(mem.mem_read_valid), 1);
        reset = 1'b0;
        step();
        check("rw_state", 32'(lsu_state), 0);
        check("rw_rvalid0", 32'(mem.mem_read_valid), 0);
        check("rw_out0", 32'(lsu_out), 0);
        reset = 1'b1; mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'hEE;
        step();
        check("rw_late_state", 32'(lsu_state), 0);
        check("rw_late_out", 32'(lsu_out), 0);
        idle_inputs();
        $display("txn reset-mid-waiting");

`ifdef LSU_TIMEOUT_EN
        // watchdog: ready never asserted, 4 WAITING cycles then DONE with error
        request(1'b1, 1'b1, 1'b0, 8'h55, 8'h00);
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            check("to_rvalid_hi", 32'(mem.mem_read_valid), 1);
        end
        step();
        check("to_rvalid_lo", 32'(mem.mem_read_valid), 0);
        check("to_state", 32'(lsu_state), 3);
        check("to_err", 32'(lsu_error), 1);
        check("to_out", 32'(lsu_out), 0);
        core_state = UPD;
        step();
        check("to_err_sticky", 32'(lsu_error), 1);
        request(1'b1, 1'b0, 1'b1, 8'h01, 8'h02);
        step();
        check("to_err_clear", 32'(lsu_error), 0);
        idle_inputs();
        step();
        mem.mem_write_ready = 1'b1;
        step();
        mem.mem_write_ready = 1'b0; core_state = UPD;
        step();
        idle_inputs();
        $display("txn timeout");
`else
        // without the watchdog a stalled request stays in WAITING
        request(1'b1, 1'b1, 1'b0, 8'h55, 8'h00);
        step();
        idle_inputs();
        for (int i = 0; i < 8; i++) step();
        check("nto_state", 32'(lsu_state), 2);
        check("nto_rvalid", 32'(mem.mem_read_valid), 1);
        check("nto_err", 32'(lsu_error), 0);
        mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'h3C;
        step();
        check("nto_out", 32'(lsu_out), 32'h3C);
        mem.mem_read_ready = 1'b0; core_state = UPD;
        step();
        idle_inputs();
        $display("txn stall-no-timeout");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Parametrised per-thread load/store unit. Sits between a thread's register file and the memory controller. Issues one read or write per instruction using a valid/ready handshake, and holds the result until the core's UPDATE phase. It generalises the single-width LSU with configurable data and address widths, core-phase sequencing, a DONE state and an optional watchdog timeout.

## Interface
Parameters:
- ADDR_BITS, 8, memory address width; the address is rs zero-extended or truncated to ADDR_BITS.
- DATA_BITS, 8, register and memory data width.
- TIMEOUT_CYCLES, 255, maximum number of WAITING cycles before abort. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- reset  in  1  reset. Synchronous and active-low.
- enable  in  1  thread active.
- core_state  in  3  core phase; REQUEST=3'b011, UPDATE=3'b110.
- mem_read_enable  in  1  decoded load.
- mem_write_enable  in  1  decoded store.
- rs  in  DATA_BITS  address operand.
- rt  in  DATA_BITS  store data.
- mem_read_valid  out  1  read request.
- mem_read_address  out  ADDR_BITS  read address.
- mem_read_ready  in  1  read complete.
- mem_read_data  in  DATA_BITS  read data.
- mem_write_valid  out  1  write request.
- mem_write_address  out  ADDR_BITS  write address.
- mem_write_data  out  DATA_BITS  write data.
- mem_write_ready  in  1  write complete.
- lsu_state  out  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
- lsu_out  out  DATA_BITS  last loaded value.
- lsu_error  out  1  timeout flag. Tied to 0 without LSU_TIMEOUT_EN.

## Operation
- One FSM drives both channels. A single operation is in flight at a time.
- IDLE -> REQUESTING when enable=1, core_state=REQUEST and (mem_read_enable or mem_write_enable).
  - The operation type, address and data are latched at this transition.
  - If both enables are high, the read wins and the write is dropped.
- REQUESTING -> WAITING unconditionally.
  - Asserts the selected valid together with the latched address (and the data, for a write).
- WAITING stays until the selected ready is sampled high.
  - Then: valid <= 0, lsu_out <= mem_read_data (read only), state -> DONE.
- DONE holds until core_state=UPDATE, then -> IDLE.
- Ready on the unselected channel, or ready while valid=0, is ignored.
- enable falling after acceptance is ignored: the operation runs to DONE.
- Address and data outputs hold their last value after valid falls.
- Reset (reset=0 at an edge), from any state:
  - state=IDLE.
  - Both valids, all addresses, mem_write_data, lsu_out and lsu_error are set to 0.
  - An in-flight request is abandoned with no completion.

## Timing
- Cycle 0: REQUEST phase sampled in IDLE.
- Cycle 1: REQUESTING.
- Cycle 2: WAITING, valid=1.
- Ready high in cycle N (N≥2) gives DONE, valid=0 and updated lsu_out in cycle N+1. Minimum request-to-DONE latency is 3 cycles.
- Valid remains high for every cycle in WAITING.
- Valid never rises in the same cycle that ready is observed.
- UPDATE sampled in DONE gives IDLE on the next cycle. A new request is accepted no earlier than the cycle after IDLE is reached.

## Configuration
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter, sized $clog2(TIMEOUT_CYCLES+1), counts WAITING cycles.
  - When the counter reaches TIMEOUT_CYCLES without ready: valid <= 0, lsu_out unchanged, lsu_error <= 1, state -> DONE.
  - lsu_error is sticky. It clears on the next IDLE->REQUESTING transition or on reset.
  - The counter clears on entry to WAITING.
- Undefined: no counter. WAITING lasts indefinitely, and lsu_error is constant 0.

## Test plan
- Reset: hold reset=0 for 2 cycles with random inputs -> all outputs 0, lsu_state=0.
- Load: rs=0x2A, REQUEST, ready in cycle 4 with data 0x5C -> read_address=0x2A; valid high in cycles 2–4; lsu_out=0x5C and state=3 in cycle 5; IDLE one cycle after UPDATE.
- Store: rs=0x10, rt=0x77, ready on the first valid cycle -> write_address=0x10, write_data=0x77, valid high for exactly 1 cycle, read_valid stays 0.
- Conflict and gating: both enables high -> only read_valid rises. enable=0 at REQUEST -> stays IDLE.
- Reset mid-WAITING: reset=0 while valid=1 -> valid=0 and state=0 on the next cycle; a later ready has no effect.
- Timeout (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted) -> valid drops after 4 WAITING cycles, lsu_error=1, state=3, lsu_out unchanged; the next request clears lsu_error.
